// File: rtl/scale_phase_ctrl_if.sv
// Handshake/configuration bundle between a line-start client and scale_phase_ctrl.
// The controller side takes the slave modport; the client takes the master modport.
interface scale_phase_ctrl_if #(
  parameter int STEP       = 4096,
  parameter int PIX_W      = 12,
  parameter int STEP_INT_W = 4
);
  localparam int FRAC   = $clog2(STEP);
  localparam int DX_W   = $clog2(STEP / 2);
  localparam int STEP_W = FRAC + STEP_INT_W;

  logic              start;
  logic [STEP_W-1:0] cfg_step;
  logic [PIX_W-1:0]  cfg_dst_w;
  logic [DX_W-1:0]   dx;
  logic [PIX_W-1:0]  src_x;
  logic              o_valid;
  logic              o_last;
  logic              o_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_step, cfg_dst_w, o_ready,
    input  dx, src_x, o_valid, o_last, busy, done
  );

  modport slave (
    input  start, cfg_step, cfg_dst_w, o_ready,
    output dx, src_x, o_valid, o_last, busy, done
  );
endinterface

// File: rtl/scale_phase_ctrl.sv
// Horizontal phase sequencer: steps a fixed-point accumulator per output pixel and
// emits ROM address dx (stage 1) plus src_x/o_valid/o_last (stage 2) with backpressure.
module scale_phase_ctrl #(
  parameter int STEP       = 4096,
  parameter int PIX_W      = 12,
  parameter int STEP_INT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  scale_phase_ctrl_if.slave  bus
);
  localparam int FRAC   = $clog2(STEP);
  localparam int DX_W   = $clog2(STEP / 2);
  localparam int ACC_W  = PIX_W + FRAC;
  localparam int STEP_W = FRAC + STEP_INT_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [STEP_W-1:0] step_q;
  logic [PIX_W-1:0]  dst_w_q;
  logic [PIX_W-1:0]  cnt_q;
  logic [DX_W-1:0]   dx_q;
  logic [PIX_W-1:0]  s1_x_q;
  logic              s1_v_q;
  logic              s1_last_q;
  logic [PIX_W-1:0]  src_x_q;
  logic              o_valid_q;
  logic              o_last_q;
  logic              busy_q;
  logic              done_q;

  logic en;
  logic last_issue;
  logic last_hs;

  assign en         = !o_valid_q || bus.o_ready;
  assign last_issue = (cnt_q == dst_w_q - PIX_W'(1));
  assign last_hs    = o_valid_q && bus.o_ready && o_last_q;

  // NOTE: every register, config latches included, is cleared by the async reset so an
  // aborted line leaves nothing behind; all state updates are non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      step_q    <= '0;
      dst_w_q   <= '0;
      cnt_q     <= '0;
      dx_q      <= '0;
      s1_x_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      src_x_q   <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (en) begin
        o_valid_q <= s1_v_q;
        src_x_q   <= s1_x_q;
        o_last_q  <= s1_last_q;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.cfg_dst_w == '0) begin
              done_q <= 1'b1;
            end else begin
              // Pixel 0 issues on the accepting edge: acc starts at 0, so the next phase is step.
              step_q    <= bus.cfg_step;
              dst_w_q   <= bus.cfg_dst_w;
              dx_q      <= '0;
              s1_x_q    <= '0;
              s1_v_q    <= 1'b1;
              s1_last_q <= (bus.cfg_dst_w == PIX_W'(1));
              acc_q     <= ACC_W'(bus.cfg_step);
              cnt_q     <= PIX_W'(1);
              busy_q    <= 1'b1;
              state_q   <= (bus.cfg_dst_w == PIX_W'(1)) ? DRAIN : RUN;
            end
          end
        end

        RUN: begin
          if (en) begin
            dx_q      <= acc_q[FRAC-1:1];
            s1_x_q    <= acc_q[ACC_W-1:FRAC];
            s1_v_q    <= 1'b1;
            s1_last_q <= last_issue;
            acc_q     <= acc_q + ACC_W'(step_q);
            cnt_q     <= cnt_q + PIX_W'(1);
            if (last_issue) state_q <= DRAIN;
          end
        end

        DRAIN: begin
          if (en) s1_v_q <= 1'b0;
          if (last_hs) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dx      = dx_q;
  assign bus.src_x   = src_x_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_scale_phase_ctrl.sv
// Self-checking bench for scale_phase_ctrl: directed scenarios plus random lines scored
// against a pixel-index arithmetic model and a model of the registered coefficient ROM.
module tb_scale_phase_ctrl;
  localparam int STEP  = 4096;
  localparam int PIX_W = 12;
  localparam int SIW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  scale_phase_ctrl_if #(.STEP(STEP), .PIX_W(PIX_W), .STEP_INT_W(SIW)) bus ();

  scale_phase_ctrl #(.STEP(STEP), .PIX_W(PIX_W), .STEP_INT_W(SIW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Registered coefficient ROM: captures dx whenever the output stage advances.
  logic [10:0] rom_dx;
  always @(posedge clk or posedge rst) begin
    if (rst) rom_dx <= '0;
    else if (!bus.o_valid || bus.o_ready) rom_dx <= bus.dx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Phase of output pixel k is k*step modulo the 24-bit accumulator range.
  function automatic longint phase(input int step, input int k);
    return (longint'(step) * longint'(k)) % (64'd1 << 24);
  endfunction
  function automatic int exp_src(input int step, input int k);
    return int'(phase(step, k) / STEP);
  endfunction
  function automatic int exp_dx(input int step, input int k);
    return int'((phase(step, k) % STEP) / 2);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_dx"},    32'(bus.dx), 0);
    check({tag, "_src"},   32'(bus.src_x), 0);
    check({tag, "_valid"}, 32'(bus.o_valid), 0);
    check({tag, "_last"},  32'(bus.o_last), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_done"},  32'(bus.done), 0);
  endtask

  // Starts a line at the current negedge and scores it until done; returns at the done negedge.
  task automatic run_line(input int step, input int n, input int stall_pct,
                          input int stall_pix, input bit poke);
    int k = 0, cyc = 0, vcyc = 0, hold = 0, last_hs = -10;
    int budget = n * 20 + 50;
    bit prev_stall = 1'b0, got_done = 1'b0, prev_last = 1'b0;
    logic [PIX_W-1:0] prev_src = '0;
    bus.start = 1'b1; bus.cfg_step = 16'(step); bus.cfg_dst_w = 12'(n); bus.o_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cfg_step = 16'($urandom); bus.cfg_dst_w = 12'($urandom);
    check("busy_rise", 32'(bus.busy), 1);
    check("dx_pix0", 32'(bus.dx), 0);
    check("valid_latency", 32'(bus.o_valid), 0);
    while (!got_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
        check("done_after_last_hs", 32'(cyc - 1), 32'(last_hs));
        check("pixel_count", 32'(k), 32'(n));
        check("busy_fall", 32'(bus.busy), 0);
        check("valid_in_done", 32'(bus.o_valid), 0);
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(bus.o_valid), 1);
          check("stall_src", 32'(bus.src_x), 32'(prev_src));
          check("stall_last", 32'(bus.o_last), 32'(prev_last));
        end
        if (bus.o_valid) vcyc++;
        if (stall_pix >= 0 && bus.o_valid && k == stall_pix && hold < 3) begin
          bus.o_ready = 1'b0;
          hold++;
          check("bp_src", 32'(bus.src_x), 32'(exp_src(step, k)));
          if (k + 1 < n) check("bp_dx", 32'(bus.dx), 32'(exp_dx(step, k + 1)));
        end else begin
          bus.o_ready = ($urandom_range(99) >= stall_pct);
        end
        if (poke && cyc == 2) begin
          check("busy_at_poke", 32'(bus.busy), 1);
          bus.start = 1'b1; bus.cfg_step = 16'($urandom); bus.cfg_dst_w = 12'($urandom);
        end
        if (bus.o_valid && bus.o_ready) begin
          if (k < n) begin
            check("src_x", 32'(bus.src_x), 32'(exp_src(step, k)));
            check("rom_dx", 32'(rom_dx), 32'(exp_dx(step, k)));
            check("o_last", 32'(bus.o_last), 32'(k == n - 1));
          end else begin
            check("extra_pixel", 32'(k), 32'(n - 1));
          end
          k++;
          last_hs = cyc;
        end
        prev_stall = bus.o_valid && !bus.o_ready;
        prev_src   = bus.src_x;
        prev_last  = bus.o_last;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    if (stall_pct == 0 && stall_pix < 0) check("throughput", 32'(vcyc), 32'(n));
    bus.start = 1'b0;
  endtask

  task automatic idle_gap;
    @(negedge clk);
    check("done_pulse_width", 32'(bus.done), 0);
    check("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_step = '0; bus.cfg_dst_w = '0; bus.o_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 2x upscale, 1.5 downscale, single pixel.
    run_line(2048, 4, 0, -1, 1'b0);
    idle_gap();
    run_line(6144, 3, 0, -1, 1'b0);
    idle_gap();
    run_line(4096, 1, 0, -1, 1'b0);
    idle_gap();

    // Backpressure: hold pixel 1 of the 2x line for three cycles.
    run_line(2048, 4, 0, 1, 1'b0);
    idle_gap();

    // Zero-width line: no pixels, single done pulse, busy never rises.
    bus.start = 1'b1; bus.cfg_step = 16'd2048; bus.cfg_dst_w = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check("zw_done", 32'(bus.done), 1);
    check("zw_busy", 32'(bus.busy), 0);
    check("zw_valid", 32'(bus.o_valid), 0);
    @(negedge clk);
    check("zw_done_once", 32'(bus.done), 0);
    check("zw_valid2", 32'(bus.o_valid), 0);

    // Start poked mid-line is ignored; a start in the done cycle opens the next line.
    run_line(3000, 10, 20, -1, 1'b1);
    run_line(5000, 6, 0, -1, 1'b0);
    idle_gap();

    // Reset after pixel 1 of an 8-pixel line.
    bus.start = 1'b1; bus.cfg_step = 16'd4096; bus.cfg_dst_w = 12'd8; bus.o_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int w = 0;
      while (!(bus.o_valid && bus.src_x == 12'd1) && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("reach_pix1", 32'(w < 20), 1);
    end
    rst = 1'b1;
    #1;
    check_all_zero("abort_now");
    @(negedge clk);
    check_all_zero("abort_next");
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_valid", 32'(bus.o_valid), 0);
      check("abort_no_done", 32'(bus.done), 0);
    end
    run_line(4096, 5, 0, -1, 1'b0);
    idle_gap();

    // Accumulator wrap at maximum step, then randomized lines under random backpressure.
    run_line(65535, 300, 10, -1, 1'b0);
    idle_gap();
    for (int i = 0; i < 10; i++) begin
      run_line(int'($urandom_range(65535, 1)), int'($urandom_range(300, 1)),
               int'($urandom_range(50)), -1, 1'b0);
      idle_gap();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scale_phase_ctrl.md
# scale_phase_ctrl

Per-line horizontal phase sequencer for the scaler2 linear interpolator. On each line start it steps a fixed-point phase accumulator over the output pixels. For every output pixel it drives the coefficient ROM address `dx` and the source pixel index `src_x`. Outputs are pipelined so that `src_x`/`o_valid` line up with the ROM's registered `coe0`/`coe1`, and downstream backpressure is honoured.

## Interface
- `STEP`, 4096: phase units per source pixel (1.0); must be a power of two.
- `PIX_W`, 12: width of pixel counts and indices.
- `STEP_INT_W`, 4: integer bits of `cfg_step`; max step just below 2^STEP_INT_W, i.e. 16x downscale.
- Derived: FRAC = $clog2(STEP); DX_W = $clog2(STEP/2); ACC_W = PIX_W+FRAC.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  line-start pulse; accepted only in IDLE.
- `cfg_step`  in  FRAC+STEP_INT_W  source advance per output pixel, in units of 1/STEP (2048 = 2x upscale).
- `cfg_dst_w`  in  PIX_W  output pixels per line.
- `dx`  out  DX_W  coefficient ROM address.
- `src_x`  out  PIX_W  integer source index of the current output pixel.
- `o_valid`  out  1  output pixel valid.
- `o_last`  out  1  last output pixel of the line; qualified by `o_valid`.
- `o_ready`  in  1  downstream accept.
- `busy`  out  1  line in progress.
- `done`  out  1  one-cycle pulse after the last pixel is accepted.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN: on `start` with `cfg_dst_w`≠0.
  - Latch `cfg_step` and `cfg_dst_w`.
  - Set acc=0, cnt=0.
  - Issue pixel 0.
- IDLE + `start` with `cfg_dst_w`=0: no pixels are issued; `done` pulses the next cycle; FSM stays in IDLE.
- Two-stage pipeline, advance enable en = !o_valid | o_ready.
- Stage 1 (issue), when en in RUN:
  - `dx` <= acc[FRAC-1:1]; s1_x <= acc[ACC_W-1:FRAC]; s1_v <= 1; s1_last <= (cnt == dst_w-1).
  - Then acc <= acc + step (mod 2^ACC_W; wraps silently, no saturation); cnt <= cnt+1.
- RUN -> DRAIN: when the last pixel is issued. In DRAIN, s1_v <= 0 when en.
- Stage 2 (output), when en: `o_valid` <= s1_v; `src_x` <= s1_x; `o_last` <= s1_last.
- The ROM samples `dx` on the same edge as stage 2, so `coe0`/`coe1` match `src_x`.
- When en=0 (stall): `dx`, stage 1 and stage 2 all hold. The held `dx` keeps the ROM output stable.
- DRAIN -> IDLE: on the handshake o_valid & o_ready & o_last.
  - `busy` <= 0 and `done` <= 1 for one cycle.
  - A `start` in that next cycle is accepted.
- `start` while `busy` is ignored.
- Config inputs are ignored except at an accepted `start`.

## Timing
- Reset value of every output: `dx`=0, `src_x`=0, `o_valid`=0, `o_last`=0, `busy`=0, `done`=0.
- Reset also clears FSM, acc, cnt and the stage-1 registers.
- `rst` asserted mid-line aborts the line immediately:
  - No further `o_valid`.
  - No `done` is produced for the aborted line.
- `start` sampled at edge E0:
  - `busy`=1 and `dx` for pixel 0 after E0.
  - `o_valid` for pixel 0 after E1, provided `o_ready` was not low against an older pixel.
- Throughput with `o_ready` held high: one pixel per cycle; a line of N pixels shows `o_valid` for N consecutive cycles.
- `done` is high in the cycle after the last handshake; `busy` falls in that same cycle.
- `o_valid` never drops without a handshake. `src_x` and `o_last` are stable while o_valid & !o_ready.

## Test plan
- 2x upscale: `cfg_step`=2048, `cfg_dst_w`=4, `o_ready`=1 -> `dx` = 0, 1024, 0, 1024; `src_x` = 0, 0, 1, 1; `o_last` on pixel 3; `done` one cycle after it.
- Downscale 1.5: `cfg_step`=6144, `cfg_dst_w`=3 -> `src_x` = 0, 1, 3; `dx` = 0, 1024, 0.
- Backpressure: the 2x case with `o_ready` low for 3 cycles while pixel 1 is valid -> `src_x`=0 and `dx`=0 (pixel 2's address) are held for the whole stall; sequence resumes without loss or duplication.
- `cfg_dst_w`=0 with `start` -> no `o_valid`; `done` pulses once; `busy` stays 0.
- `start` pulsed mid-line -> ignored; the line completes with the original config. A `start` in the `done` cycle begins a new line.
- `rst` asserted after pixel 1 of an 8-pixel line -> all outputs are 0 next cycle and no `done`; a following `start` restarts at `src_x`=0.
